// File: rtl/intr_sequencer.sv
// intr_sequencer: fixed-priority interrupt initiator that drives the register file's save/restore pulses and the fetch redirect.
// Define INTC_EDGE_DETECT_EN to latch rising request edges; the default build runs in level mode.
module intr_sequencer #(
    parameter int          NUM_IRQ    = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter int unsigned VEC_STRIDE = 32'd4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               ex_valid,
    input  logic [31:0]        pc_EX,
    input  logic [1:0]         flags,
    input  logic               iret_ex,
    output logic               interrupt,
    output logic               Iret,
    output logic               flush,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic               in_service,
    output logic [2:0]         active_id
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SAVE    = 3'd1;
    localparam logic [2:0] ST_VECTOR  = 3'd2;
    localparam logic [2:0] ST_SERVICE = 3'd3;
    localparam logic [2:0] ST_RETURN  = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next;
    logic [31:0]        r_epc;
    logic [31:0]        w_vec_pc;
    logic [NUM_IRQ-1:0] w_pending;
    logic [NUM_IRQ-1:0] w_eligible;
    logic [NUM_IRQ-1:0] w_one;
    logic [NUM_IRQ-1:0] w_lowest;
    logic [2:0]         w_winner;
    logic               w_take;
    logic               w_unused;

    // Flags travel straight to the register file; this block only sequences the pulses.
    assign w_unused = ^flags;

`ifdef INTC_EDGE_DETECT_EN
    logic [NUM_IRQ-1:0] r_irq_q;
    logic [NUM_IRQ-1:0] r_pending;
    logic [NUM_IRQ-1:0] w_clr;

    assign w_clr     = w_take ? w_lowest : {NUM_IRQ{1'b0}};
    assign w_pending = r_pending;

    // Latch rising request edges; a fresh edge outranks the clear of the bit being taken.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_q   <= {NUM_IRQ{1'b0}};
            r_pending <= {NUM_IRQ{1'b0}};
        end else begin
            r_irq_q   <= irq_in;
            r_pending <= (r_pending & ~w_clr) | (irq_in & ~r_irq_q);
        end
    end
`else
    assign w_pending = irq_in;
`endif

    // Isolate the lowest eligible request (two's-complement trick) and encode its index.
    always_comb begin
        w_eligible = w_pending & ~irq_mask;
        w_one      = {NUM_IRQ{1'b0}};
        w_one[0]   = 1'b1;
        w_lowest   = w_eligible & (~w_eligible + w_one);
        w_winner   = 3'd0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_winner = w_winner | (w_lowest[i] ? i[2:0] : 3'd0);
        end
    end

    // Next-state logic of the save / vector / service / return sequence.
    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if ((w_eligible != {NUM_IRQ{1'b0}}) && ex_valid) begin
                    w_next = ST_SAVE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_SAVE:    w_next = ST_VECTOR;
            ST_VECTOR:  w_next = ST_SERVICE;
            ST_SERVICE: begin
                if (iret_ex) begin
                    w_next = ST_RETURN;
                end else begin
                    w_next = ST_SERVICE;
                end
            end
            ST_RETURN:  w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    assign w_take   = (r_state == ST_IDLE) && (w_next == ST_SAVE);
    assign w_vec_pc = VEC_BASE + ({29'd0, active_id} * VEC_STRIDE);

    // Outputs are decoded from the next state so every pulse is a clean register output.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_epc          <= 32'd0;
            interrupt      <= 1'b0;
            Iret           <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            in_service     <= 1'b0;
            active_id      <= 3'd0;
        end else begin
            r_state        <= w_next;
            interrupt      <= (w_next == ST_SAVE);
            Iret           <= (w_next == ST_RETURN);
            flush          <= (w_next == ST_SAVE) || (w_next == ST_RETURN);
            redirect_valid <= (w_next == ST_VECTOR) || (w_next == ST_RETURN);
            in_service     <= (w_next == ST_VECTOR) || (w_next == ST_SERVICE) ||
                              (w_next == ST_RETURN);
            if (w_take) begin
                r_epc     <= pc_EX;
                active_id <= w_winner;
            end else begin
                r_epc     <= r_epc;
                active_id <= active_id;
            end
            case (w_next)
                ST_VECTOR: redirect_pc <= w_vec_pc;
                ST_RETURN: redirect_pc <= r_epc;
                default:   redirect_pc <= 32'd0;
            endcase
        end
    end

endmodule
